// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
//   clock. Optional two's-complement input, overflow detection with
//   saturation to all-nines, and a start/busy/done handshake.
//
// Parameters
//   WIDTH  : binary input width (>= 2)
//   DIGITS : number of BCD output digits (>= 1)
//   SIGNED : 1 = bin is two's complement (its magnitude is converted)
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : conversion request, sampled only while idle
//   bin    : value to convert, sampled on the accepting edge
//   busy   : conversion in progress
//   done   : one-cycle pulse when bcd/neg/ovf update
//   bcd    : result, digit k at bcd[4k+3:4k], digit 0 = ones
//   neg    : result sign (always 0 when SIGNED=0)
//   ovf    : magnitude exceeded 10^DIGITS-1 (bcd saturated to all nines)
module bin2bcd_seq #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   state_t              r_state, w_state_nxt;
   logic                w_accept, w_last;

   logic [WIDTH-1:0]    r_m;
   logic [4*DIGITS-1:0] r_scr;
   logic                r_sticky;
   logic                r_sgn;
   logic [CW-1:0]       r_cnt;

   logic [4*DIGITS-1:0] r_bcd;
   logic                r_done, r_neg, r_ovf;

   logic                w_sgn_in;
   logic [WIDTH-1:0]    w_mag;
   logic [4*DIGITS-1:0] w_adj;
   logic [4*DIGITS-1:0] w_scr_sh;
   logic                w_ovf_now;
   logic                w_ovf_final;

   // Magnitude of the input; the most-negative value wraps to 2^(WIDTH-1),
   // which is the correct unsigned magnitude.
   assign w_sgn_in = (SIGNED != 0) ? bin[WIDTH-1] : 1'b0;
   assign w_mag    = w_sgn_in ? (~bin + 1'b1) : bin;

   // Per-digit add-3 correction, 4-bit with no carry between digits.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ? (r_scr[4*g +: 4] + 4'd3)
                                                          : r_scr[4*g +: 4];
   end

   // Shift {scratch, m} left by one; the bit leaving the top digit is overflow.
   assign w_scr_sh    = {w_adj[4*DIGITS-2:0], r_m[WIDTH-1]};
   assign w_ovf_now   = w_adj[4*DIGITS-1];
   assign w_ovf_final = r_sticky | w_ovf_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == CW'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m      <= '0;
         r_scr    <= '0;
         r_sticky <= 1'b0;
         r_sgn    <= 1'b0;
         r_cnt    <= '0;
         r_bcd    <= '0;
         r_done   <= 1'b0;
         r_neg    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_m      <= w_mag;
            r_sgn    <= w_sgn_in;
            r_scr    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= CW'(WIDTH);
         end else if (r_state == S_SHIFT) begin
            r_m      <= {r_m[WIDTH-2:0], 1'b0};
            r_scr    <= w_scr_sh;
            r_sticky <= w_ovf_final;
            r_cnt    <= r_cnt - 1'b1;
            if (w_last) begin
               // Overflow on the final shift itself must also saturate.
               r_bcd  <= w_ovf_final ? {DIGITS{4'h9}} : w_scr_sh;
               r_ovf  <= w_ovf_final;
               r_neg  <= r_sgn;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = (r_state == S_SHIFT);
   assign done = r_done;
   assign bcd  = r_bcd;
   assign neg  = r_neg;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start0, starto;
   logic [13:0] b0, b1, b2;
   logic [7:0]  b3;
   logic [9:0]  b4;
   logic [4:0]  bsy, dn, ng, ov;
   logic [19:0] bcd0;
   logic [15:0] bcd1, bcd2;
   logic [7:0]  bcd3;
   logic [11:0] bcd4;

   int checks = 0;
   int fails  = 0;

   bin2bcd_seq #(.WIDTH(14), .DIGITS(5), .SIGNED(0)) u0 (.clk(clk), .rst(rst), .start(start0), .bin(b0),
      .busy(bsy[0]), .done(dn[0]), .bcd(bcd0), .neg(ng[0]), .ovf(ov[0]));
   bin2bcd_seq #(.WIDTH(14), .DIGITS(4), .SIGNED(0)) u1 (.clk(clk), .rst(rst), .start(starto), .bin(b1),
      .busy(bsy[1]), .done(dn[1]), .bcd(bcd1), .neg(ng[1]), .ovf(ov[1]));
   bin2bcd_seq #(.WIDTH(14), .DIGITS(4), .SIGNED(1)) u2 (.clk(clk), .rst(rst), .start(starto), .bin(b2),
      .busy(bsy[2]), .done(dn[2]), .bcd(bcd2), .neg(ng[2]), .ovf(ov[2]));
   bin2bcd_seq #(.WIDTH(8),  .DIGITS(2), .SIGNED(1)) u3 (.clk(clk), .rst(rst), .start(starto), .bin(b3),
      .busy(bsy[3]), .done(dn[3]), .bcd(bcd3), .neg(ng[3]), .ovf(ov[3]));
   bin2bcd_seq #(.WIDTH(10), .DIGITS(3), .SIGNED(0)) u4 (.clk(clk), .rst(rst), .start(starto), .bin(b4),
      .busy(bsy[4]), .done(dn[4]), .bcd(bcd4), .neg(ng[4]), .ovf(ov[4]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer magnitude, clamp to 10^d-1, then decimal digits.
   // Returns {neg, ovf, bcd[31:0]}.
   function automatic logic [33:0] model(input int w, input int d, input int s, input logic [31:0] b);
      longint v, lim;
      logic [31:0] r;
      logic n, o;
      v = longint'(b);
      n = (s != 0) && b[w-1];
      if (n) v = (longint'(1) << w) - v;
      lim = 1;
      for (int k = 0; k < d; k++) lim = lim * 10;
      lim = lim - 1;
      o = (v > lim);
      if (o) v = lim;
      r = '0;
      for (int k = 0; k < d; k++) begin
         r = r | (32'(v % 10) << (4 * k));
         v = v / 10;
      end
      return {n, o, r};
   endfunction

   task automatic chk_inst(input string tag, input int w, input int d, input int s,
                           input logic [31:0] x, input logic [31:0] obcd, input logic on, input logic oo);
      logic [33:0] e;
      e = model(w, d, s, x);
      chk({tag, "_bcd"}, obcd, e[31:0]);
      chk({tag, "_ovf"}, {31'd0, oo}, {31'd0, e[32]});
      chk({tag, "_neg"}, {31'd0, on}, {31'd0, e[33]});
   endtask

   // One conversion on all instances; a spurious start with new bins is
   // injected mid-conversion and must be ignored.
   task automatic convert(input logic [13:0] x0, input logic [13:0] x1, input logic [13:0] x2,
                          input logic [7:0] x3, input logic [9:0] x4);
      int dcnt [5];
      int bcnt, dk;
      @(negedge clk);
      b0 = x0; b1 = x1; b2 = x2; b3 = x3; b4 = x4;
      start0 = 1'b1; starto = 1'b1;
      @(negedge clk);
      start0 = 1'b0; starto = 1'b0;
      bcnt = bsy[0] ? 1 : 0;
      dk = -1;
      for (int i = 0; i < 5; i++) dcnt[i] = 0;
      for (int k = 1; k <= 24; k++) begin
         if (k == 5) begin
            start0 = 1'b1; starto = 1'b1;
            b0 = 14'($urandom); b1 = 14'($urandom); b2 = 14'($urandom);
            b3 = 8'($urandom);  b4 = 10'($urandom);
         end
         @(negedge clk);
         if (k == 5) begin start0 = 1'b0; starto = 1'b0; end
         for (int i = 0; i < 5; i++) if (dn[i]) dcnt[i]++;
         if (dn[0] && dk < 0) dk = k;
         if (bsy[0]) bcnt++;
      end
      for (int i = 0; i < 5; i++) chk($sformatf("done_pulses_u%0d", i), 32'(dcnt[i]), 32'd1);
      chk("u0_done_edge", 32'(dk), 32'd14);
      chk("u0_busy_cycles", 32'(bcnt), 32'd14);
      chk_inst("u0", 14, 5, 0, {18'd0, x0}, {12'd0, bcd0}, ng[0], ov[0]);
      chk_inst("u1", 14, 4, 0, {18'd0, x1}, {16'd0, bcd1}, ng[1], ov[1]);
      chk_inst("u2", 14, 4, 1, {18'd0, x2}, {16'd0, bcd2}, ng[2], ov[2]);
      chk_inst("u3", 8,  2, 1, {24'd0, x3}, {24'd0, bcd3}, ng[3], ov[3]);
      chk_inst("u4", 10, 3, 0, {22'd0, x4}, {20'd0, bcd4}, ng[4], ov[4]);
   endtask

   initial begin
      int n, last, dcount;
      logic [19:0] exp_b2b [3];
      rst = 1'b1; start0 = 1'b0; starto = 1'b0;
      b0 = '0; b1 = '0; b2 = '0; b3 = '0; b4 = '0;
      #12;
      chk("rst_busy", {27'd0, bsy}, 32'd0);
      chk("rst_done", {27'd0, dn}, 32'd0);
      chk("rst_bcd0", {12'd0, bcd0}, 32'd0);
      chk("rst_negovf", {22'd0, ng, ov}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed corners.
      chk("exp_16383", model(14, 5, 0, 32'd16383), {2'b00, 32'h16383});
      convert(14'd16383, 14'd9999, 14'h2000, 8'h80, 10'd999);
      chk("u0_16383", {12'd0, bcd0}, 32'h16383);
      chk("u1_9999", {16'd0, bcd1}, 32'h9999);
      chk("u2_m8192", {15'd0, ng[2], bcd2}, 32'h18192);
      convert(14'd0, 14'd10000, 14'h3FFF, 8'd99, 10'd1000);
      chk("u1_10000", {15'd0, ov[1], bcd1}, 32'h19999);
      chk("u2_m1", {15'd0, ng[2], bcd2}, 32'h10001);
      convert(14'd1, 14'd0, 14'd0, 8'd100, 10'd0);
      chk("u1_zero", {15'd0, ov[1], bcd1}, 32'h00000);
      chk("u2_zero_neg", {31'd0, ng[2]}, 32'd0);

      // start held high: bin is stepped only on accept edges.
      exp_b2b[0] = 20'h00001; exp_b2b[1] = 20'h00002; exp_b2b[2] = 20'h00003;
      @(negedge clk);
      b0 = 14'd1; start0 = 1'b1;
      n = 0; last = 0;
      for (int k = 1; k <= 60 && n < 3; k++) begin
         @(negedge clk);
         if (dn[0]) begin
            chk($sformatf("b2b_res%0d", n), {12'd0, bcd0}, {12'd0, exp_b2b[n]});
            if (n > 0) chk($sformatf("b2b_gap%0d", n), 32'(k - last), 32'd15);
            last = k;
            n++;
            if (n == 3) start0 = 1'b0;
            else b0 = 14'(n + 1);
         end else begin
            b0 = 14'($urandom);
         end
      end
      chk("b2b_count", 32'(n), 32'd3);
      start0 = 1'b0;

      // Asynchronous reset mid-conversion.
      convert(14'd1234, 14'd42, 14'h3FFF, 8'd7, 10'd5);
      @(negedge clk);
      b0 = 14'd999; b2 = 14'h3FFE; start0 = 1'b1; starto = 1'b1;
      @(negedge clk);
      start0 = 1'b0; starto = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {27'd0, bsy}, 32'd0);
      chk("arst_done", {27'd0, dn}, 32'd0);
      chk("arst_bcd0", {12'd0, bcd0}, 32'd0);
      chk("arst_bcd2", {16'd0, bcd2}, 32'd0);
      chk("arst_negovf", {22'd0, ng, ov}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      repeat (25) begin
         @(negedge clk);
         if (dn != 5'd0) dcount++;
      end
      chk("arst_no_done", 32'(dcount), 32'd0);
      convert(14'd4321, 14'd8765, 14'h3000, 8'hF6, 10'd512);

      // Randomised sweep over all configurations.
      for (int r = 0; r < 150; r++)
         convert(14'($urandom), 14'($urandom), 14'($urandom), 8'($urandom), 10'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
